// File: rtl/mdu_pkg.sv
// Shared constants, op codes and FSM state encoding for the HI/LO multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  // Signed ops take absolute values on capture and sign-fix the result.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate of a W-bit value.
// Latency: combinational.
// Backpressure: none.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; MTHI/MTLO write directly.
// Latency: MULT/DIV results on hi/lo with done 33 cycles after accept; MTHI/MTLO visible next cycle.
// Backpressure: none; start is dropped while busy, the hazard logic must hold requests off.
module mdu_hilo #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

  state_t               state;
  logic [5:0]           cnt;
  // MUL: {partial product high, multiplier shifting out}. DIV: low half is dividend/quotient.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;
  // Multiplicand for MUL, divisor for DIV (absolute value).
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     rs_raw;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz;
  logic                 is_div;

  logic                 sgn;
  logic [WIDTH-1:0]     abs_rs;
  logic [WIDTH-1:0]     abs_rt;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       part_rem;
  logic [WIDTH:0]       div_diff;
  logic                 borrow;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign sgn = op_is_signed(op);

  mdu_sign_fix #(.W(WIDTH)) u_abs_rs (
    .val (rs_data),
    .neg (sgn & rs_data[WIDTH-1]),
    .res (abs_rs)
  );

  mdu_sign_fix #(.W(WIDTH)) u_abs_rt (
    .val (rt_data),
    .neg (sgn & rt_data[WIDTH-1]),
    .res (abs_rt)
  );

  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .val (acc),
    .neg (neg_q),
    .res (prod_fix)
  );

  mdu_sign_fix #(.W(WIDTH)) u_quo_fix (
    .val (acc[WIDTH-1:0]),
    .neg (neg_q),
    .res (quo_fix)
  );

  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (
    .val (rem),
    .neg (neg_r),
    .res (rem_fix)
  );

  // Shift-add step: add the multiplicand into the high half when the current multiplier LSB is set.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};

  // Restoring-division step on the 33-bit partial remainder; bit WIDTH of the difference is the borrow.
  assign part_rem = {rem, acc[WIDTH-1]};
  assign div_diff = part_rem - {1'b0, opnd};
  assign borrow   = div_diff[WIDTH];

  assign last_iter = (cnt == LAST_ITER);
  assign busy      = (state != IDLE);

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      rs_raw <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state  <= MUL;
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, abs_rt};
                opnd   <= abs_rs;
                neg_q  <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                neg_r  <= sgn & rs_data[WIDTH-1];
                is_div <= 1'b0;
                dz     <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state  <= DIV;
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, abs_rs};
                rem    <= '0;
                opnd   <= abs_rt;
                rs_raw <= rs_data;
                neg_q  <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                neg_r  <= sgn & rs_data[WIDTH-1];
                is_div <= 1'b1;
                dz     <= (rt_data == '0);
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
          if (last_iter) state <= FIXUP;
        end
        DIV: begin
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~borrow};
          rem            <= borrow ? part_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
          cnt            <= cnt + 6'd1;
          if (last_iter) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            // Divide by zero reports all-ones quotient and the raw dividend as remainder.
            if (dz) begin
              lo <= '1;
              hi <= rs_raw;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with HI/LO architectural registers for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over 33 cycles and services MTHI/MTLO in one cycle. Its `hi` and `lo` outputs feed the 32-bit 4-to-1 writeback/result multiplexer for MFHI/MFLO. The `busy` output goes to the hazard logic so the pipeline stalls MFHI/MFLO until the result is valid.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. The design is only verified at 32.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: request strobe. It is sampled on the rising edge.
- `op` in 3: operation code. Values: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6 and 7 are reserved.
- `rs_data` in 32: multiplicand or dividend. Also the MTHI/MTLO source.
- `rt_data` in 32: multiplier or divisor.
- `busy` out 1: high while a MULT/DIV is in flight.
- `done` out 1: one-cycle pulse. HI/LO are valid and updated in this cycle.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0. State is IDLE. All working registers are cleared.
- **States:** IDLE, MUL, DIV, FIXUP. `busy` = (state != IDLE).
- **IDLE:**
  - `start` with MULT/MULTU → MUL.
  - `start` with DIV/DIVU → DIV.
  - `start` with MTHI → `hi` <= `rs_data`; stay in IDLE. MTLO does the same for `lo`.
  - Reserved op codes are ignored.
- **`start` while busy:** ignored, including MTHI/MTLO. No error is flagged; the hazard logic prevents it.
- **Operand capture (on acceptance):**
  - Store |rs| and |rt|. Absolute values apply to signed ops only; unsigned ops capture operands unchanged.
  - Store `neg_q` = rs[31]^rt[31] and `neg_r` = rs[31]. Both are forced to 0 for unsigned ops.
  - Clear the 6-bit iteration counter.
- **MUL:**
  - 32 iterations of shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - After the 32nd iteration → FIXUP.
- **DIV:**
  - 32 iterations of restoring division, one quotient bit per cycle, MSB first.
  - Uses a 33-bit partial remainder. Subtraction width is 33 bits, so the borrow is bit 32.
  - After the 32nd iteration → FIXUP.
- **FIXUP (one cycle):**
  - MUL: the product is negated (two's complement, 64-bit) if `neg_q`. Then `hi` <= product[63:32] and `lo` <= product[31:0].
  - DIV: `lo` <= quotient, negated if `neg_q`. `hi` <= remainder, negated if `neg_r`.
  - Assert `done`, then go to IDLE.
- **Divide by zero:** `lo`=0xFFFFFFFF and `hi`=dividend as presented on `rs_data` (raw). This holds for both DIV and DIVU. The full 33-cycle latency is still taken.
- **DIV 0x80000000 / 0xFFFFFFFF:** `lo`=0x80000000, `hi`=0. No trap.
- **Architectural HI/LO:** `hi`/`lo` hold their old values through MUL/DIV. They change only in FIXUP or on MTHI/MTLO.
- **Reset mid-operation:** the operation is aborted. All outputs return to reset values immediately, without waiting for a clock edge.

## Timing
- **Acceptance edge E0:** `busy` is high from after E0 through E33.
- **Iterations:** edges E1..E32.
- **FIXUP:** edge E33 writes `hi`/`lo`. `done`=1 and `busy`=0 for the cycle after E33.
- **Latency:** 33 cycles from the accepting edge to result-valid.
- **Back-to-back:** `start` may be accepted on the edge ending the `done` cycle.
- **MTHI/MTLO:** the written value is visible on `hi`/`lo` in the cycle after the accepting edge. `done` is not asserted.
- **Reset deassertion:** synchronized externally. After deassertion, the first edge may accept `start`.

## Structure
- **Package `mdu_pkg`:**
  - `WIDTH` constant.
  - Op-code localparams: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - State encoding: IDLE=2'd0, MUL=2'd1, DIV=2'd2, FIXUP=2'd3.
  - Iteration count constant: 32.
- **Sub-module `mdu_sign_fix`:** combinational conditional two's-complement negate (parameterised width). It is used for operand absolute values, the 64-bit product and the quotient/remainder fixups.
- **Top level:** the FSM, counter, accumulator/remainder registers and HI/LO registers stay in the top level.

## Test plan
1. **MULTU max × max:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` is exactly 33 cycles after the accepting edge. `busy` is high for 33 cycles.
2. **Signed multiply:** MULT 0xFFFFFFFD × 0x00000007 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
3. **Signed and unsigned divide:**
   - DIV 0xFFFFFFF9 / 0x00000002 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
   - DIVU 7 / 2 → `lo`=3, `hi`=1.
4. **Divide corner cases:**
   - DIVU 0x00001234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00001234.
   - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
5. **Busy and HI/LO stability:**
   - MTHI 0xA5A5A5A5 → `hi`=0xA5A5A5A5 next cycle, with no `done`.
   - Then start a MULT, and issue `start` with MTLO and DIV mid-flight. Both are ignored.
   - `hi` stays 0xA5A5A5A5 until the FIXUP edge.
6. **Reset mid-divide:**
   - Drop `reset_n` 10 cycles into a DIV → `busy`=0 and `hi`=`lo`=0 with no clock edge.
   - After release, MULTU 3 × 5 → `lo`=15, `hi`=0.
